// File: rtl/rob_pkg.sv
// Reorder-buffer entry layout and widths shared by rename, issue and the ROB.
// The functions here give one shared definition of what a retiring entry returns to rename.
package rob_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int PREG_W    = 6;
    localparam int PC_W      = 8;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] old_pd;
        logic [PC_W-1:0]   pc;
    } rob_entry_t;

    // An instr writing x0 (pd==0), or one whose old mapping is p0, has nothing to give back.
    function automatic logic frees_preg(input rob_entry_t e);
        return (e.pd != '0) && (e.old_pd != '0);
    endfunction

    function automatic logic can_retire(input rob_entry_t e);
        return e.valid & e.done;
    endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer.
// Occupancy is tracked as an explicit count, so full and empty never depend on head/tail equality.
module rob_ptr_ctrl #(
    parameter  int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [1:0]       alloc_n,
    input  logic [1:0]       retire_n,
    output logic [IDX_W-1:0] head,
    output logic [IDX_W-1:0] tail,
    output logic             alloc_ready,
    output logic             empty
);

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every next-state value is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        head_d  = head_q + IDX_W'(retire_n);
        tail_d  = tail_q + IDX_W'(alloc_n);
        count_d = count_q + CNT_W'(alloc_n) - CNT_W'(retire_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head = head_q;
    assign tail = tail_q;

    // Room for a full pair is judged on the registered count; same-cycle retires are not credited.
    assign alloc_ready = (count_q <= CNT_W'(DEPTH - 2));
    assign empty       = (count_q == '0);

endmodule

// File: rtl/reorder_buffer.sv
// 2-wide in-order-retire reorder buffer: allocates renamed instrs at tail, marks them done on
// writeback, and retires up to two done entries per cycle from head with registered outputs.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter  int DEPTH = ROB_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    output logic              alloc_ready,
    input  logic              alloc1_valid,
    input  logic [PC_W-1:0]   alloc1_pc,
    input  logic [PREG_W-1:0] alloc1_pd,
    input  logic [PREG_W-1:0] alloc1_old_pd,
    output logic [IDX_W-1:0]  alloc1_idx,
    input  logic              alloc2_valid,
    input  logic [PC_W-1:0]   alloc2_pc,
    input  logic [PREG_W-1:0] alloc2_pd,
    input  logic [PREG_W-1:0] alloc2_old_pd,
    output logic [IDX_W-1:0]  alloc2_idx,
    input  logic              comp1_valid,
    input  logic [IDX_W-1:0]  comp1_idx,
    input  logic              comp2_valid,
    input  logic [IDX_W-1:0]  comp2_idx,
    output logic              retire1f,
    output logic [PREG_W-1:0] retire1reg,
    output logic [PC_W-1:0]   retire1_pc,
    output logic              retire2f,
    output logic [PREG_W-1:0] retire2reg,
    output logic [PC_W-1:0]   retire2_pc,
    output logic [1:0]        retire_cnt,
    output logic              empty
);

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    rob_entry_t       rob_q [DEPTH];
    rob_entry_t       head_e, next_e;
    logic [IDX_W-1:0] head, tail, head_nxt;
    logic             acc1, acc2, ret1, ret2;
    logic [1:0]       alloc_n, retire_n;

    logic              retire1f_q, retire2f_q;
    logic [PREG_W-1:0] retire1reg_q, retire2reg_q;
    logic [PC_W-1:0]   retire1_pc_q, retire2_pc_q;
    logic [1:0]        retire_cnt_q;

    // Slot 2 packs behind slot 1 only when slot 1 actually carries an instr.
    assign alloc1_idx = tail;
    assign alloc2_idx = tail + IDX_W'(alloc1_valid);
    assign acc1       = alloc1_valid & alloc_ready;
    assign acc2       = alloc2_valid & alloc_ready;
    assign alloc_n    = {1'b0, acc1} + {1'b0, acc2};

    assign head_nxt = head + IDX_ONE;
    assign head_e   = rob_q[head];
    assign next_e   = rob_q[head_nxt];
    assign ret1     = can_retire(head_e);
    assign ret2     = ret1 & can_retire(next_e);
    assign retire_n = {1'b0, ret1} + {1'b0, ret2};

    rob_ptr_ctrl #(
        .DEPTH(DEPTH)
    ) u_ptr_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .alloc_n     (alloc_n),
        .retire_n    (retire_n),
        .head        (head),
        .tail        (tail),
        .alloc_ready (alloc_ready),
        .empty       (empty)
    );

    // NOTE: the whole entry array is reset because valid/done must clear asynchronously; payload
    // fields are cleared with them so retire outputs never expose stale or X data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) rob_q[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i].valid <= 1'b0;
                rob_q[i].done  <= 1'b0;
            end
        end else begin
            if (comp1_valid && rob_q[comp1_idx].valid) rob_q[comp1_idx].done <= 1'b1;
            if (comp2_valid && rob_q[comp2_idx].valid) rob_q[comp2_idx].done <= 1'b1;
            if (ret1) begin
                rob_q[head].valid <= 1'b0;
                rob_q[head].done  <= 1'b0;
            end
            if (ret2) begin
                rob_q[head_nxt].valid <= 1'b0;
                rob_q[head_nxt].done  <= 1'b0;
            end
            // Later writes win: a fresh allocation always lands as valid and not yet done.
            if (acc1) begin
                rob_q[alloc1_idx] <= '{valid: 1'b1, done: 1'b0, pd: alloc1_pd,
                                       old_pd: alloc1_old_pd, pc: alloc1_pc};
            end
            if (acc2) begin
                rob_q[alloc2_idx] <= '{valid: 1'b1, done: 1'b0, pd: alloc2_pd,
                                       old_pd: alloc2_old_pd, pc: alloc2_pc};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
            retire1f_q   <= 1'b0;
            retire1reg_q <= '0;
            retire1_pc_q <= '0;
            retire2f_q   <= 1'b0;
            retire2reg_q <= '0;
            retire2_pc_q <= '0;
        end else if (flush) begin
            retire_cnt_q <= '0;
            retire1f_q   <= 1'b0;
            retire1reg_q <= '0;
            retire1_pc_q <= '0;
            retire2f_q   <= 1'b0;
            retire2reg_q <= '0;
            retire2_pc_q <= '0;
        end else begin
            retire_cnt_q <= retire_n;
            retire1f_q   <= ret1 & frees_preg(head_e);
            retire1reg_q <= ret1 ? head_e.old_pd : '0;
            retire1_pc_q <= ret1 ? head_e.pc : '0;
            retire2f_q   <= ret2 & frees_preg(next_e);
            retire2reg_q <= ret2 ? next_e.old_pd : '0;
            retire2_pc_q <= ret2 ? next_e.pc : '0;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign retire1f   = retire1f_q;
    assign retire1reg = retire1reg_q;
    assign retire1_pc = retire1_pc_q;
    assign retire2f   = retire2f_q;
    assign retire2reg = retire2reg_q;
    assign retire2_pc = retire2_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a vector table for the basic flows, hand-written
// sequences for fill/wrap, flush and async reset, and an in-order retire scoreboard.
module tb_reorder_buffer;
    import rob_pkg::*;

    localparam int DEPTH = ROB_DEPTH;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NVEC  = 20;

    logic              clk, rst_n, flush;
    logic              alloc_ready, empty;
    logic              alloc1_valid, alloc2_valid;
    logic [PC_W-1:0]   alloc1_pc, alloc2_pc;
    logic [PREG_W-1:0] alloc1_pd, alloc1_old_pd, alloc2_pd, alloc2_old_pd;
    logic [IDX_W-1:0]  alloc1_idx, alloc2_idx;
    logic              comp1_valid, comp2_valid;
    logic [IDX_W-1:0]  comp1_idx, comp2_idx;
    logic              retire1f, retire2f;
    logic [PREG_W-1:0] retire1reg, retire2reg;
    logic [PC_W-1:0]   retire1_pc, retire2_pc;
    logic [1:0]        retire_cnt;

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .alloc_ready   (alloc_ready),
        .alloc1_valid  (alloc1_valid),
        .alloc1_pc     (alloc1_pc),
        .alloc1_pd     (alloc1_pd),
        .alloc1_old_pd (alloc1_old_pd),
        .alloc1_idx    (alloc1_idx),
        .alloc2_valid  (alloc2_valid),
        .alloc2_pc     (alloc2_pc),
        .alloc2_pd     (alloc2_pd),
        .alloc2_old_pd (alloc2_old_pd),
        .alloc2_idx    (alloc2_idx),
        .comp1_valid   (comp1_valid),
        .comp1_idx     (comp1_idx),
        .comp2_valid   (comp2_valid),
        .comp2_idx     (comp2_idx),
        .retire1f      (retire1f),
        .retire1reg    (retire1reg),
        .retire1_pc    (retire1_pc),
        .retire2f      (retire2f),
        .retire2reg    (retire2reg),
        .retire2_pc    (retire2_pc),
        .retire_cnt    (retire_cnt),
        .empty         (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected the run to finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        int old_pd;
        int pc;
        int f;
    } exp_t;

    typedef struct {
        int a1v, pd1, old1, a2v, pd2, old2;
        int c1v, c1i, c2v, c2i;
        int e_idx1, e_idx2, e_cnt, e_empty;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[NVEC];
    int   n_vec, n_err;
    int   mcnt, mtail, pc_ctr, retired_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected_retire(input string name, input logic [31:0] reg_v);
        n_vec++;
        n_err++;
        $display("FAIL %s: got retire of old_pd %0d, expected no retire (t=%0t)", name, reg_v, $time);
    endtask

    // Pops the scoreboard for every slot the DUT reports retired; idle slots must read as zero.
    task automatic monitor();
        exp_t e;
        retired_total += int'(retire_cnt);
        mcnt          -= int'(retire_cnt);
        if (retire_cnt >= 2'd1) begin
            if (sb.size() == 0) unexpected_retire("ret1_unexpected", 32'(retire1reg));
            else begin
                e = sb.pop_front();
                check("ret1_reg", 32'(retire1reg), e.old_pd);
                check("ret1_pc",  32'(retire1_pc), e.pc);
                check("ret1_f",   32'(retire1f),   e.f);
            end
        end else begin
            check("ret1_idle", 32'({retire1f, retire1reg, retire1_pc}), 32'd0);
        end
        if (retire_cnt >= 2'd2) begin
            if (sb.size() == 0) unexpected_retire("ret2_unexpected", 32'(retire2reg));
            else begin
                e = sb.pop_front();
                check("ret2_reg", 32'(retire2reg), e.old_pd);
                check("ret2_pc",  32'(retire2_pc), e.pc);
                check("ret2_f",   32'(retire2f),   e.f);
            end
        end else begin
            check("ret2_idle", 32'({retire2f, retire2reg, retire2_pc}), 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    // Drives one cycle of alloc/complete inputs, checks occupancy flags and tags against the
    // bench model, and records accepted instrs in program order on the scoreboard.
    task automatic drive(input int a1v, input int pd1, input int old1,
                         input int a2v, input int pd2, input int old2,
                         input int c1v, input int c1i, input int c2v, input int c2i);
        bit acc;
        acc = (mcnt <= DEPTH - 2);
        check("alloc_ready", 32'(alloc_ready), 32'(acc));
        check("empty", 32'(empty), 32'(mcnt == 0));
        alloc1_valid  = a1v[0];
        alloc1_pd     = pd1[PREG_W-1:0];
        alloc1_old_pd = old1[PREG_W-1:0];
        alloc1_pc     = pc_ctr[PC_W-1:0];
        alloc2_valid  = a2v[0];
        alloc2_pd     = pd2[PREG_W-1:0];
        alloc2_old_pd = old2[PREG_W-1:0];
        alloc2_pc     = PC_W'(pc_ctr + 1);
        comp1_valid   = c1v[0];
        comp1_idx     = c1i[IDX_W-1:0];
        comp2_valid   = c2v[0];
        comp2_idx     = c2i[IDX_W-1:0];
        #1;
        check("alloc1_idx", 32'(alloc1_idx), 32'(mtail));
        check("alloc2_idx", 32'(alloc2_idx), 32'((mtail + a1v) % DEPTH));
        if (acc) begin
            if (a1v != 0) begin
                sb.push_back('{old1, pc_ctr % 256, int'(pd1 != 0 && old1 != 0)});
                mcnt++;
                mtail = (mtail + 1) % DEPTH;
            end
            if (a2v != 0) begin
                sb.push_back('{old2, (pc_ctr + 1) % 256, int'(pd2 != 0 && old2 != 0)});
                mcnt++;
                mtail = (mtail + 1) % DEPTH;
            end
        end
        pc_ctr += 2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_clear();
        sb.delete();
        mcnt  = 0;
        mtail = 0;
    endtask

    initial begin
        int t0;
        n_vec = 0; n_err = 0; mcnt = 0; mtail = 0; pc_ctr = 0; retired_total = 0;
        rst_n = 1'b0; flush = 1'b0;
        alloc1_valid = 1'b0; alloc1_pc = '0; alloc1_pd = '0; alloc1_old_pd = '0;
        alloc2_valid = 1'b0; alloc2_pc = '0; alloc2_pd = '0; alloc2_old_pd = '0;
        comp1_valid = 1'b0; comp1_idx = '0; comp2_valid = 1'b0; comp2_idx = '0;

        //             a1v pd1 old1 a2v pd2 old2 c1v c1i c2v c2i idx1 idx2 cnt empty
        tbl[0]  = '{0,  0,  0,  0,  0,  0,  0, 0, 0, 0,  0,  0, 0, 1};
        tbl[1]  = '{1, 33,  5,  1, 34,  6,  0, 0, 0, 0,  0,  1, 0, 0};
        tbl[2]  = '{0,  0,  0,  0,  0,  0,  1, 0, 1, 1,  2,  2, 0, 0};
        tbl[3]  = '{0,  0,  0,  0,  0,  0,  0, 0, 0, 0,  2,  2, 2, 1};
        tbl[4]  = '{1, 10,  1,  1, 11,  2,  0, 0, 0, 0,  2,  3, 0, 0};
        tbl[5]  = '{0,  0,  0,  0,  0,  0,  1, 3, 0, 0,  4,  4, 0, 0};
        tbl[6]  = '{0,  0,  0,  0,  0,  0,  0, 0, 0, 0,  4,  4, 0, 0};
        tbl[7]  = '{0,  0,  0,  0,  0,  0,  0, 0, 1, 2,  4,  4, 0, 0};
        tbl[8]  = '{0,  0,  0,  0,  0,  0,  0, 0, 0, 0,  4,  4, 2, 1};
        tbl[9]  = '{1,  0,  7,  0,  0,  0,  0, 0, 0, 0,  4,  5, 0, 0};
        tbl[10] = '{0,  0,  0,  0,  0,  0,  1, 4, 1, 4,  5,  5, 0, 0};
        tbl[11] = '{0,  0,  0,  0,  0,  0,  0, 0, 0, 0,  5,  5, 1, 1};
        tbl[12] = '{0,  0,  0,  1, 20,  0,  1, 9, 0, 0,  5,  5, 0, 0};
        tbl[13] = '{0,  0,  0,  0,  0,  0,  0, 0, 1, 5,  6,  6, 0, 0};
        tbl[14] = '{0,  0,  0,  0,  0,  0,  0, 0, 0, 0,  6,  6, 1, 1};
        tbl[15] = '{1, 40,  8,  1, 41,  9,  0, 0, 0, 0,  6,  7, 0, 0};
        tbl[16] = '{0,  0,  0,  0,  0,  0,  1, 6, 1, 7,  8,  8, 0, 0};
        tbl[17] = '{1, 42, 10,  1, 43, 11,  0, 0, 0, 0,  8,  9, 2, 0};
        tbl[18] = '{0,  0,  0,  0,  0,  0,  1, 8, 1, 9, 10, 10, 0, 0};
        tbl[19] = '{0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 10, 10, 2, 1};

        // Reset state, sampled while rst_n is still held low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_empty",       32'(empty),       32'd1);
        check("rst_retire_cnt",  32'(retire_cnt),  32'd0);
        check("rst_retire1",     32'({retire1f, retire1reg, retire1_pc}), 32'd0);
        check("rst_retire2",     32'({retire2f, retire2reg, retire2_pc}), 32'd0);
        check("rst_alloc1_idx",  32'(alloc1_idx),  32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].a1v, tbl[i].pd1, tbl[i].old1, tbl[i].a2v, tbl[i].pd2, tbl[i].old2,
                  tbl[i].c1v, tbl[i].c1i, tbl[i].c2v, tbl[i].c2i);
            check("tbl_idx1", 32'(alloc1_idx), tbl[i].e_idx1);
            check("tbl_idx2", 32'(alloc2_idx), tbl[i].e_idx2);
            tick();
            check("tbl_retire_cnt", 32'(retire_cnt), tbl[i].e_cnt);
            check("tbl_empty",      32'(empty),      tbl[i].e_empty);
        end

        // Fill with eight pairs, try one dropped pair, then complete in order and drain.
        t0 = mtail;
        retired_total = 0;
        for (int p = 0; p < 8; p++) begin
            drive(1, 1 + 2 * p, 17 + 2 * p, 1, 2 + 2 * p, 18 + 2 * p, 0, 0, 0, 0);
            tick();
        end
        check("full_alloc_ready", 32'(alloc_ready), 32'd0);
        drive(1, 60, 61, 1, 62, 63, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1, (t0 + 2 * k) % DEPTH, 1, (t0 + 2 * k + 1) % DEPTH);
            tick();
        end
        for (int w = 0; w < 8 && mcnt > 0; w++) begin
            idle();
            tick();
        end
        check("fill_retired", 32'(retired_total), 32'd16);
        check("fill_sb_left", 32'(sb.size()),     32'd0);
        check("fill_tail_wrapped", 32'(alloc1_idx), 32'(t0));

        // Five entries, the two oldest done; flush with a completion and an alloc in the same cycle.
        drive(1, 21, 3, 1, 22, 4, 0, 0, 0, 0);  tick();
        drive(1, 23, 5, 1, 24, 6, 0, 0, 0, 0);  tick();
        drive(1, 25, 7, 0, 0, 0, 0, 0, 0, 0);   tick();
        drive(0, 0, 0, 0, 0, 0, 1, (t0 + 0) % DEPTH, 1, (t0 + 1) % DEPTH);
        tick();
        flush        = 1'b1;
        alloc1_valid = 1'b1;
        alloc2_valid = 1'b1;
        comp1_valid  = 1'b1;
        comp1_idx    = IDX_W'((t0 + 2) % DEPTH);
        comp2_valid  = 1'b0;
        model_clear();
        tick();
        flush = 1'b0;
        check("flush_retire_cnt",  32'(retire_cnt),  32'd0);
        check("flush_empty",       32'(empty),       32'd1);
        check("flush_alloc_ready", 32'(alloc_ready), 32'd1);
        idle(); tick();
        check("flush_next_retire", 32'(retire_cnt), 32'd0);
        idle(); tick();
        drive(1, 30, 12, 0, 0, 0, 0, 0, 0, 0);  tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);    tick();
        idle(); tick();
        check("post_flush_retire_cnt", 32'(retire_cnt), 32'd1);

        // Async reset pulse between clock edges while a retire is being presented.
        drive(1, 35, 13, 1, 36, 14, 0, 0, 0, 0); tick();
        drive(1, 37, 15, 1, 38, 16, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 2);     tick();
        idle(); tick();
        check("pre_reset_retire_cnt", 32'(retire_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        check("arst_retire_cnt",  32'(retire_cnt),  32'd0);
        check("arst_retire1",     32'({retire1f, retire1reg, retire1_pc}), 32'd0);
        check("arst_retire2",     32'({retire2f, retire2reg, retire2_pc}), 32'd0);
        check("arst_empty",       32'(empty),       32'd1);
        check("arst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("arst_alloc1_idx",  32'(alloc1_idx),  32'd0);
        model_clear();
        #1;
        rst_n = 1'b1;
        idle(); tick();
        idle(); tick();
        drive(1, 39, 17, 1, 40, 18, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);     tick();
        idle(); tick();
        check("post_reset_retire_cnt", 32'(retire_cnt), 32'd2);
        idle(); tick();
        check("final_sb_left", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
